// File: rtl/bus_pkg.sv
// Shared types and lane constants for the bus_master initiator and its byte-steering logic.
package bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int         NUM_LANES  = 4;
  localparam int         LANE_W     = 8;
  localparam logic [3:0] MASK_BYTE0 = 4'b1000;
  localparam logic [3:0] MASK_HALF0 = 4'b1100;
  localparam logic [3:0] MASK_HALF1 = 4'b0011;
  localparam logic [3:0] MASK_WORD  = 4'b1111;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sign;
    logic [15:0] addr;
    logic [31:0] data;
    logic        err;
  } req_t;

  // Illegal size or an address not aligned to the access size.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    logic e;
    case (size_e'(size))
      SZ_BYTE: e = 1'b0;
      SZ_HALF: e = off[0];
      SZ_WORD: e = (off != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Big-endian byte steering: store replication/mask and load lane extraction/extension.
module lane_align
  import bus_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_mask_o,
  output logic [31:0] ld_data_o
);

  // lane[k] is the byte at address offset k (offset 0 sits in the MSBs).
  logic [NUM_LANES-1:0][LANE_W-1:0] lane;
  logic [7:0]                       byte_sel;
  logic [15:0]                      half_sel;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane[k] = ld_raw_i[31-8*k -: 8];
  end

  assign byte_sel = lane[offset_i];
  assign half_sel = offset_i[1] ? {lane[2], lane[3]} : {lane[0], lane[1]};

  always_comb begin
    wr_data_o = st_data_i;
    wr_mask_o = MASK_WORD;
    case (size_e'(size_i))
      SZ_BYTE: begin
        wr_data_o = {4{st_data_i[7:0]}};
        wr_mask_o = MASK_BYTE0 >> offset_i;
      end
      SZ_HALF: begin
        wr_data_o = {2{st_data_i[15:0]}};
        wr_mask_o = offset_i[1] ? MASK_HALF1 : MASK_HALF0;
      end
      SZ_WORD: wr_mask_o = MASK_WORD;
      default: wr_mask_o = 4'b0000;
    endcase
  end

  always_comb begin
    ld_data_o = ld_raw_i;
    case (size_e'(size_i))
      SZ_BYTE: ld_data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: ld_data_o = {{16{sign_i & half_sel[15]}}, half_sel};
      default: ld_data_o = ld_raw_i;
    endcase
  end

endmodule

// File: rtl/bus_master.sv
// CPU-to-memory bus initiator: one registered access at a time, fixed-latency reads.
module bus_master
  import bus_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [15:0] req_address,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic [15:0] address,
  output logic [31:0] data_out,
  output logic [3:0]  write_mask,
  output logic        bus_enable,
  output logic        write_enable,
  input  logic [31:0] data_in
);

  localparam logic [2:0] CNT_LAST = 3'(READ_LATENCY - 1);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        accept, read_last;
  logic [31:0] wr_data, ld_data;
  logic [3:0]  wr_mask;

  assign accept    = (state_q == S_IDLE) && req_valid;
  assign read_last = (state_q == S_READ) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (access_err(req_size, req_address[1:0])) state_d = S_DONE;
          else if (req_write)                         state_d = S_WRITE;
          else                                        state_d = S_READ;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_READ:  if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are frozen at acceptance; the CPU may change req_* freely afterwards.
  always_comb begin
    req_d = req_q;
    if (accept) begin
      req_d.write = req_write;
      req_d.size  = req_size;
      req_d.sign  = req_sign;
      req_d.addr  = req_address;
      req_d.data  = req_data;
      req_d.err   = access_err(req_size, req_address[1:0]);
    end
    cnt_d   = ((state_q == S_READ) && !read_last) ? cnt_q + 3'd1 : 3'd0;
    rdata_d = read_last ? data_in : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= '0;
      cnt_q   <= 3'd0;
      rdata_q <= 32'd0;
    end else begin
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  lane_align u_align (
    .size_i    (req_q.size),
    .sign_i    (req_q.sign),
    .offset_i  (req_q.addr[1:0]),
    .st_data_i (req_q.data),
    .ld_raw_i  (rdata_q),
    .wr_data_o (wr_data),
    .wr_mask_o (wr_mask),
    .ld_data_o (ld_data)
  );

  // All outputs decode from state, so an async reset clears them in the same cycle.
  always_comb begin
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_data     = 32'd0;
    rsp_error    = 1'b0;
    address      = 16'd0;
    data_out     = 32'd0;
    write_mask   = 4'd0;
    bus_enable   = 1'b0;
    write_enable = 1'b0;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_WRITE: begin
        address      = {req_q.addr[15:2], 2'b00};
        bus_enable   = 1'b1;
        write_enable = 1'b1;
        write_mask   = wr_mask;
        data_out     = wr_data;
      end
      S_READ: begin
        address    = {req_q.addr[15:2], 2'b00};
        bus_enable = 1'b1;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_error = req_q.err;
        rsp_data  = (req_q.err || req_q.write) ? 32'd0 : ld_data;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: one instance with READ_LATENCY=1, one with 3.
module tb_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        rv1, rv3;
  logic        req_write, req_sign;
  logic [1:0]  req_size;
  logic [15:0] req_address;
  logic [31:0] req_data, data_in;

  logic        rr1, rsv1, rse1, be1, we1;
  logic [31:0] rsd1, do1;
  logic [15:0] ad1;
  logic [3:0]  wm1;
  logic        rr3, rsv3, rse3, be3, we3;
  logic [31:0] rsd3, do3;
  logic [15:0] ad3;
  logic [3:0]  wm3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bus_master #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rr1), .req_write(req_write),
    .req_size(req_size), .req_sign(req_sign), .req_address(req_address), .req_data(req_data),
    .rsp_valid(rsv1), .rsp_data(rsd1), .rsp_error(rse1), .address(ad1), .data_out(do1),
    .write_mask(wm1), .bus_enable(be1), .write_enable(we1), .data_in(data_in)
  );

  bus_master #(.READ_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(rv3), .req_ready(rr3), .req_write(req_write),
    .req_size(req_size), .req_sign(req_sign), .req_address(req_address), .req_data(req_data),
    .rsp_valid(rsv3), .rsp_data(rsd3), .rsp_error(rse3), .address(ad3), .data_out(do3),
    .write_mask(wm3), .bus_enable(be3), .write_enable(we3), .data_in(data_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store1(input string tag, input logic [1:0] sz, input logic [15:0] a,
                        input logic [31:0] d, input logic [15:0] ea, input logic [3:0] em,
                        input logic [31:0] ed);
    req_write = 1'b1; req_size = sz; req_sign = 1'b0; req_address = a; req_data = d; rv1 = 1'b1;
    chk({tag, " c0 ready"}, 32'(rr1), 32'd1);
    tick();
    rv1 = 1'b0; req_address = 16'hFFFF; req_data = 32'h5555_5555; req_size = 2'd3; req_write = 1'b0;
    chk({tag, " c1 addr"}, 32'(ad1), 32'(ea));
    chk({tag, " c1 mask"}, 32'(wm1), 32'(em));
    chk({tag, " c1 data"}, do1, ed);
    chk({tag, " c1 we"}, 32'(we1), 32'd1);
    chk({tag, " c1 be"}, 32'(be1), 32'd1);
    chk({tag, " c1 ready"}, 32'(rr1), 32'd0);
    chk({tag, " c1 rsv"}, 32'(rsv1), 32'd0);
    tick();
    chk({tag, " c2 rsv"}, 32'(rsv1), 32'd1);
    chk({tag, " c2 err"}, 32'(rse1), 32'd0);
    chk({tag, " c2 rdata"}, rsd1, 32'd0);
    chk({tag, " c2 be"}, 32'(be1), 32'd0);
    chk({tag, " c2 dout"}, do1, 32'd0);
    chk({tag, " c2 mask"}, 32'(wm1), 32'd0);
    tick();
    chk({tag, " c3 rsv"}, 32'(rsv1), 32'd0);
    chk({tag, " c3 ready"}, 32'(rr1), 32'd1);
  endtask

  task automatic load1(input string tag, input logic [1:0] sz, input logic sgn,
                       input logic [15:0] a, input logic [15:0] ea, input logic [31:0] din,
                       input logic [31:0] exp);
    req_write = 1'b0; req_size = sz; req_sign = sgn; req_address = a; req_data = 32'd0;
    data_in = din; rv1 = 1'b1;
    tick();
    rv1 = 1'b0; req_sign = ~sgn; req_size = 2'd3; req_address = 16'hFFFF;
    chk({tag, " c1 be"}, 32'(be1), 32'd1);
    chk({tag, " c1 we"}, 32'(we1), 32'd0);
    chk({tag, " c1 mask"}, 32'(wm1), 32'd0);
    chk({tag, " c1 addr"}, 32'(ad1), 32'(ea));
    chk({tag, " c1 rsv"}, 32'(rsv1), 32'd0);
    tick();
    data_in = 32'd0;
    chk({tag, " c2 rsv"}, 32'(rsv1), 32'd1);
    chk({tag, " c2 err"}, 32'(rse1), 32'd0);
    chk({tag, " c2 rdata"}, rsd1, exp);
    tick();
    chk({tag, " c3 rsv"}, 32'(rsv1), 32'd0);
  endtask

  task automatic err1(input string tag, input logic [1:0] sz, input logic [15:0] a);
    req_write = 1'b1; req_size = sz; req_sign = 1'b0; req_address = a;
    req_data = 32'hFFFF_FFFF; data_in = 32'hFFFF_FFFF; rv1 = 1'b1;
    tick();
    rv1 = 1'b0;
    chk({tag, " c1 rsv"}, 32'(rsv1), 32'd1);
    chk({tag, " c1 err"}, 32'(rse1), 32'd1);
    chk({tag, " c1 rdata"}, rsd1, 32'd0);
    chk({tag, " c1 be"}, 32'(be1), 32'd0);
    chk({tag, " c1 we"}, 32'(we1), 32'd0);
    tick();
    chk({tag, " c2 rsv"}, 32'(rsv1), 32'd0);
    chk({tag, " c2 err"}, 32'(rse1), 32'd0);
    chk({tag, " c2 be"}, 32'(be1), 32'd0);
    chk({tag, " c2 ready"}, 32'(rr1), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rv1 = 1'b0; rv3 = 1'b0; req_write = 1'b0; req_sign = 1'b0; req_size = 2'd0;
    req_address = 16'd0; req_data = 32'd0; data_in = 32'd0;
    tick();
    chk("rst ready1", 32'(rr1), 32'd1);
    chk("rst ready3", 32'(rr3), 32'd1);
    chk("rst rsv1", 32'(rsv1), 32'd0);
    chk("rst be1", 32'(be1), 32'd0);
    chk("rst addr1", 32'(ad1), 32'd0);
    chk("rst dout1", do1, 32'd0);
    chk("rst rdata1", rsd1, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    store1("st_b1",  2'd0, 16'h0005, 32'h0000_00AB, 16'h0004, 4'b0100, 32'hABAB_ABAB);
    store1("st_h0",  2'd1, 16'h0100, 32'h1234_BEEF, 16'h0100, 4'b1100, 32'hBEEF_BEEF);
    store1("st_h2",  2'd1, 16'h0102, 32'h1234_BEEF, 16'h0100, 4'b0011, 32'hBEEF_BEEF);
    store1("st_w",   2'd2, 16'h0008, 32'hCAFE_F00D, 16'h0008, 4'b1111, 32'hCAFE_F00D);
    store1("st_b3",  2'd0, 16'h00FF, 32'h1234_5678, 16'h00FC, 4'b0001, 32'h7878_7878);

    load1("ld_h2s",  2'd1, 1'b1, 16'h0012, 16'h0010, 32'h1234_F00D, 32'hFFFF_F00D);
    load1("ld_h2u",  2'd1, 1'b0, 16'h0012, 16'h0010, 32'h1234_F00D, 32'h0000_F00D);
    load1("ld_h0s",  2'd1, 1'b1, 16'h0010, 16'h0010, 32'h7FFF_8000, 32'h0000_7FFF);
    load1("ld_b0s",  2'd0, 1'b1, 16'h0020, 16'h0020, 32'h8012_3456, 32'hFFFF_FF80);
    load1("ld_b3u",  2'd0, 1'b0, 16'h0023, 16'h0020, 32'h8012_34F7, 32'h0000_00F7);
    load1("ld_b3s",  2'd0, 1'b1, 16'h0023, 16'h0020, 32'h8012_34F7, 32'hFFFF_FFF7);
    load1("ld_b1s",  2'd0, 1'b1, 16'h0021, 16'h0020, 32'h0045_0000, 32'h0000_0045);
    load1("ld_ws",   2'd2, 1'b1, 16'h0004, 16'h0004, 32'h8000_0001, 32'h8000_0001);

    err1("err_wmis", 2'd2, 16'h0002);
    err1("err_sz3",  2'd3, 16'h0000);
    err1("err_hodd", 2'd1, 16'h0001);

    // L=3 word load: only the last READ cycle's data_in may be captured.
    req_write = 1'b0; req_size = 2'd2; req_sign = 1'b0; req_address = 16'hC000;
    data_in = 32'h1111_1111; rv3 = 1'b1;
    chk("l3 c0 ready", 32'(rr3), 32'd1);
    tick();
    rv3 = 1'b0; req_address = 16'h0000;
    chk("l3 c1 be", 32'(be3), 32'd1);
    chk("l3 c1 addr", 32'(ad3), 32'h0000_C000);
    chk("l3 c1 rsv", 32'(rsv3), 32'd0);
    tick();
    chk("l3 c2 be", 32'(be3), 32'd1);
    chk("l3 c2 rsv", 32'(rsv3), 32'd0);
    tick();
    data_in = 32'hDEAD_BEEF;
    chk("l3 c3 be", 32'(be3), 32'd1);
    chk("l3 c3 we", 32'(we3), 32'd0);
    chk("l3 c3 mask", 32'(wm3), 32'd0);
    chk("l3 c3 rsv", 32'(rsv3), 32'd0);
    tick();
    data_in = 32'd0;
    chk("l3 c4 rsv", 32'(rsv3), 32'd1);
    chk("l3 c4 rdata", rsd3, 32'hDEAD_BEEF);
    chk("l3 c4 be", 32'(be3), 32'd0);
    tick();
    chk("l3 c5 rsv", 32'(rsv3), 32'd0);
    chk("l3 c5 ready", 32'(rr3), 32'd1);

    // Reset in the middle of an L=3 read.
    req_size = 2'd2; req_address = 16'h0040; data_in = 32'h0BAD_0BAD; rv3 = 1'b1;
    tick();
    rv3 = 1'b0;
    chk("rmid c1 be", 32'(be3), 32'd1);
    tick();
    chk("rmid c2 be", 32'(be3), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rmid be", 32'(be3), 32'd0);
    chk("rmid addr", 32'(ad3), 32'd0);
    chk("rmid ready", 32'(rr3), 32'd1);
    chk("rmid rsv", 32'(rsv3), 32'd0);
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rmid post rsv", 32'(rsv3), 32'd0);
      chk("rmid post be", 32'(be3), 32'd0);
    end
    chk("rmid post ready", 32'(rr3), 32'd1);

    // Back-to-back with req_valid held high.
    req_write = 1'b0; req_size = 2'd0; req_sign = 1'b0; req_address = 16'h0030;
    data_in = 32'h5AC3_0000; rv1 = 1'b1;
    tick();
    chk("b2b c1 ready", 32'(rr1), 32'd0);
    chk("b2b c1 be", 32'(be1), 32'd1);
    tick();
    chk("b2b c2 rsv", 32'(rsv1), 32'd1);
    chk("b2b c2 rdata", rsd1, 32'h0000_005A);
    chk("b2b c2 ready", 32'(rr1), 32'd0);
    tick();
    chk("b2b c3 ready", 32'(rr1), 32'd1);
    chk("b2b c3 rsv", 32'(rsv1), 32'd0);
    chk("b2b c3 be", 32'(be1), 32'd0);
    req_address = 16'h0031;
    tick();
    rv1 = 1'b0;
    chk("b2b c4 be", 32'(be1), 32'd1);
    chk("b2b c4 addr", 32'(ad1), 32'h0000_0030);
    chk("b2b c4 ready", 32'(rr1), 32'd0);
    tick();
    chk("b2b c5 rsv", 32'(rsv1), 32'd1);
    chk("b2b c5 rdata", rsd1, 32'h0000_00C3);
    tick();
    chk("b2b c6 rsv", 32'(rsv1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1, meaning bus_enable cycles held per read before capture; legal range 1..7.
REQ-002 SHALL have port clk  input  1  the single clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  CPU access request.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
REQ-008 SHALL have port req_sign  input  1  sign-extend loaded byte or halfword.
REQ-009 SHALL have port req_address  input  16  byte address.
REQ-010 SHALL have port req_data  input  32  store data, right-justified.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_data  output  32  load result; 0 for stores and errors.
REQ-013 SHALL have port rsp_error  output  1  misaligned or illegal size; valid with rsp_valid.
REQ-014 SHALL have ports address (output, 16), data_out (output, 32), write_mask (output, 4), bus_enable (output, 1), write_enable (output, 1), data_in (input, 32), forming the memory-bus initiator side.

Function
REQ-015 SHALL implement states IDLE, WRITE, READ, DONE; req_ready SHALL be high only in IDLE.
REQ-016 SHALL register all request fields on acceptance (cycle 0); later changes to req_* SHALL have no effect.
REQ-017 SHALL flag an error when req_size = 3, or when size = 1 and addr[0] = 1, or when size = 2 and addr[1:0] != 0; on error it SHALL go IDLE->DONE, assert no bus strobes, and return rsp_error = 1 with rsp_data = 0.
REQ-018 SHALL drive address = {req_address[15:2], 2'b00} during WRITE and READ, and 0 otherwise.
REQ-019 SHALL use big-endian lanes: byte offset k occupies data bits [31-8k : 24-8k]; write_mask[i] enables bits [8i+7 : 8i].
REQ-020 Store masks SHALL be: byte offset k -> 4'b1000 >> k; halfword offset 0 -> 4'b1100, offset 2 -> 4'b0011; word -> 4'b1111.
REQ-021 Store data SHALL be replicated: byte -> {4{b}}, halfword -> {2{h}}, word -> unchanged.
REQ-022 WRITE SHALL last exactly 1 cycle (cycle 1), with bus_enable = write_enable = 1 and the mask and data of REQ-020/021; then DONE.
REQ-023 READ SHALL last READ_LATENCY cycles (cycles 1..L) with bus_enable = 1, write_enable = 0 and write_mask = 0; data_in SHALL be captured on the last READ cycle.
REQ-024 Loads SHALL extract the addressed lane and zero-extend it, or sign-extend it when req_sign = 1; req_sign SHALL be ignored for word loads.
REQ-025 DONE SHALL last 1 cycle with rsp_valid = 1, then return to IDLE; latency is write 2, read L+1, error 1 cycles after acceptance.
REQ-026 rsp_valid has no backpressure; a new request MAY be accepted the cycle after DONE.
REQ-027 Outside WRITE/READ, bus_enable, write_enable and write_mask SHALL be 0 and data_out SHALL be 0.

Reset
REQ-028 Reset assertion SHALL immediately force IDLE, clearing all outputs to 0 except req_ready, which SHALL be 1; this SHALL hold even mid-access.
REQ-029 An access aborted by reset SHALL produce no rsp_valid; a partially strobed store is not retried.

Structure
REQ-030 A shared package bus_pkg SHALL hold the size codes, the state enumeration and the lane/mask constants.
REQ-031 Byte steering (store replication and mask, load extraction and extension) SHALL be a combinational sub-module lane_align; the FSM and counter SHALL remain in bus_master.

Verification
REQ-032 Byte store: addr 0x0005, data 0x000000AB -> cycle 1 address 0x0004, mask 4'b0100, data_out 0xABABABAB, write_enable 1; rsp_valid at cycle 2.
REQ-033 Signed halfword load, L = 1: addr 0x0012, data_in 0x1234F00D -> rsp_data 0xFFFFF00D at cycle 2; with req_sign = 0 -> 0x0000F00D.
REQ-034 Word load, L = 3: addr 0xC000 -> bus_enable high on cycles 1-3; data_in 0xDEADBEEF -> rsp_data 0xDEADBEEF, rsp_valid at cycle 4.
REQ-035 Misaligned word at 0x0002, and separately size 3 -> rsp_error 1 at cycle 1, bus_enable never asserted.
REQ-036 Reset asserted on cycle 2 of an L = 3 read -> outputs cleared within the same cycle, no rsp_valid, req_ready 1.
REQ-037 Back-to-back requests with req_valid held high -> second request accepted the cycle after rsp_valid, and req_ready low during the first access.
